// File: rtl/reorder_buffer.sv
// Circular reorder buffer: N-wide in-order dispatch at the tail, N-wide in-order retire at the head.
// Optional macro REORDER_BUFFER_SPOT_BYPASS_EN lets same-cycle retires free spots for dispatch.
module reorder_buffer #(
    parameter int N      = 3,
    parameter int ROB_SZ = 32,
    parameter int PREG_W = 6,
    parameter int CNT_W  = $clog2(N + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    input  logic [N*2*PREG_W-1:0] rob_inputs,
    input  logic [CNT_W-1:0]      rob_inputs_valid,
    output logic [CNT_W-1:0]      rob_spots,
    output logic [N*2*PREG_W-1:0] rob_outputs,
    output logic [CNT_W-1:0]      rob_outputs_valid,
    input  logic [CNT_W-1:0]      num_retiring
);
    localparam int PKT_W = 2 * PREG_W;
    localparam int PTR_W = $clog2(ROB_SZ);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] N_C  = CW'(N);
    localparam logic [CW-1:0] SZ_C = CW'(ROB_SZ);

    logic [PKT_W-1:0] entries [ROB_SZ];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CW-1:0]    count;

    logic [CW-1:0] occ_lanes;
    logic [CW-1:0] ret_req;
    logic [CW-1:0] acc_r;
    logic [CW-1:0] free_cnt;
    logic [CW-1:0] spots;
    logic [CW-1:0] disp_req;
    logic [CW-1:0] acc_d;

    // Handshake: dispatch offers rob_inputs_valid lanes and min(offer, rob_spots) are taken,
    // the rest are dropped; retire pops min(num_retiring, rob_outputs_valid) head entries.
    always_comb begin
        occ_lanes = (count > N_C) ? N_C : count;
        ret_req   = CW'(num_retiring);
        acc_r     = (ret_req < occ_lanes) ? ret_req : occ_lanes;
`ifdef REORDER_BUFFER_SPOT_BYPASS_EN
        free_cnt  = SZ_C - count + acc_r;
`else
        free_cnt  = SZ_C - count;
`endif
        spots     = (free_cnt > N_C) ? N_C : free_cnt;
        disp_req  = CW'(rob_inputs_valid);
        acc_d     = (disp_req < spots) ? disp_req : spots;
    end

    assign rob_spots         = CNT_W'(spots);
    assign rob_outputs_valid = CNT_W'(occ_lanes);

    // Head lanes read in age order; modular pointer addition handles the wrap at ROB_SZ-1.
    always_comb begin
        rob_outputs = '0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) < occ_lanes) begin
                rob_outputs[i*PKT_W +: PKT_W] = entries[head + PTR_W'(i)];
            end
        end
    end

    // Payload storage needs no reset: only slots between head and tail are ever exposed.
    always_ff @(posedge clock) begin
        if (!squash) begin
            for (int i = 0; i < N; i++) begin
                if (CW'(i) < acc_d) begin
                    entries[tail + PTR_W'(i)] <= rob_inputs[i*PKT_W +: PKT_W];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(acc_r);
            tail  <= tail + PTR_W'(acc_d);
            count <= count + acc_d - acc_r;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic against a queue model.
module tb_reorder_buffer;
    localparam int N      = 3;
    localparam int ROB_SZ = 8;
    localparam int PREG_W = 6;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int PKT_W  = 2 * PREG_W;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  squash = 1'b0;
    logic [N*PKT_W-1:0]    rob_inputs = '0;
    logic [CNT_W-1:0]      rob_inputs_valid = '0;
    logic [CNT_W-1:0]      rob_spots;
    logic [N*PKT_W-1:0]    rob_outputs;
    logic [CNT_W-1:0]      rob_outputs_valid;
    logic [CNT_W-1:0]      num_retiring = '0;

    int checks = 0;
    int failures = 0;
    logic [PKT_W-1:0]  exp_q[$];
    logic [PREG_W-1:0] next_tnew = 1;

    reorder_buffer #(.N(N), .ROB_SZ(ROB_SZ), .PREG_W(PREG_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .squash            (squash),
        .rob_inputs        (rob_inputs),
        .rob_inputs_valid  (rob_inputs_valid),
        .rob_spots         (rob_spots),
        .rob_outputs       (rob_outputs),
        .rob_outputs_valid (rob_outputs_valid),
        .num_retiring      (num_retiring)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PREG_W-1:0] lane_tnew(input int lane);
        return rob_outputs[lane*PKT_W + PREG_W +: PREG_W];
    endfunction

    // Expected outputs follow directly from the queue of in-flight packets, oldest first.
    task automatic check_outputs(input string tag);
        int v;
        int s;
        logic [N*PKT_W-1:0] exp_out;
        exp_out = '0;
        v = (exp_q.size() < N) ? exp_q.size() : N;
        s = ROB_SZ - exp_q.size();
        if (s > N) s = N;
        for (int i = 0; i < v; i++) exp_out[i*PKT_W +: PKT_W] = exp_q[i];
        check({tag, ".valid"}, 64'(rob_outputs_valid), 64'(v));
        check({tag, ".spots"}, 64'(rob_spots), 64'(s));
        check({tag, ".lanes"}, 64'(rob_outputs), 64'(exp_out));
    endtask

    // Called at a negedge: drive one cycle of stimulus, update the model at the edge, check.
    task automatic cycle(input int iv, input int nr, input bit sq, input string tag);
        logic [PKT_W-1:0] lanes [N];
        int occ;
        int acc_r;
        int spots;
        int acc_d;
        for (int i = 0; i < N; i++) begin
            lanes[i] = {next_tnew + PREG_W'(i), PREG_W'($urandom_range(0, 63))};
            rob_inputs[i*PKT_W +: PKT_W] = lanes[i];
        end
        rob_inputs_valid = CNT_W'(iv);
        num_retiring     = CNT_W'(nr);
        squash           = sq;
        occ   = (exp_q.size() < N) ? exp_q.size() : N;
        acc_r = (nr < occ) ? nr : occ;
`ifdef REORDER_BUFFER_SPOT_BYPASS_EN
        spots = ROB_SZ - exp_q.size() + acc_r;
`else
        spots = ROB_SZ - exp_q.size();
`endif
        if (spots > N) spots = N;
        acc_d = (iv < spots) ? iv : spots;
        @(posedge clock);
        if (sq) begin
            exp_q.delete();
        end else begin
            repeat (acc_r) void'(exp_q.pop_front());
            for (int i = 0; i < acc_d; i++) exp_q.push_back(lanes[i]);
            next_tnew = next_tnew + PREG_W'(acc_d);
        end
        #1;
        rob_inputs_valid = '0;
        num_retiring     = '0;
        squash           = 1'b0;
        @(negedge clock);
        check_outputs(tag);
    endtask

    initial begin
        logic [PREG_W-1:0] base;
        logic [PREG_W-1:0] e1;
        logic [PREG_W-1:0] e2;

        // Reset asserted near t0 takes effect without a clock edge.
        #1 reset = 1'b0;
        #1;
        check("rst.valid", 64'(rob_outputs_valid), 64'd0);
        check("rst.spots", 64'(rob_spots), 64'd3);
        check("rst.lanes", 64'(rob_outputs), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_outputs("release");

        // Fill 3,3,2 with T_new 1..8.
        cycle(3, 0, 0, "fill0");
        cycle(3, 0, 0, "fill1");
        cycle(2, 0, 0, "fill2");
        check("full.spots", 64'(rob_spots), 64'd0);
        check("full.valid", 64'(rob_outputs_valid), 64'd3);
        check("full.t0", 64'(lane_tnew(0)), 64'd1);
        check("full.t1", 64'(lane_tnew(1)), 64'd2);
        check("full.t2", 64'(lane_tnew(2)), 64'd3);

`ifdef REORDER_BUFFER_SPOT_BYPASS_EN
        cycle(2, 2, 0, "full_bypass");
        check("bypass.head", 64'(lane_tnew(0)), 64'd3);
        check("bypass.spots", 64'(rob_spots), 64'd0);
`else
        cycle(2, 0, 0, "full_drop");
        check("drop.head", 64'(lane_tnew(0)), 64'd1);
        check("drop.spots", 64'(rob_spots), 64'd0);
`endif

        // Squash beats same-cycle dispatch and retire.
        cycle(0, 3, 0, "to5");
        cycle(3, 2, 1, "squash");
        check("squash.valid", 64'(rob_outputs_valid), 64'd0);
        check("squash.spots", 64'(rob_spots), 64'd3);

        // Position head at 5 with three live entries, then retire 3 and dispatch 3 across the wrap.
        cycle(3, 0, 0, "refill0");
        cycle(3, 0, 0, "refill1");
        cycle(2, 0, 0, "refill2");
        cycle(0, 3, 0, "ret3");
        cycle(0, 2, 0, "ret2");
        base = next_tnew;
        e1 = base + 1'b1;
        e2 = base + 2'd2;
        cycle(3, 3, 0, "wrap");
        check("wrap.valid", 64'(rob_outputs_valid), 64'd3);
        check("wrap.t0", 64'(lane_tnew(0)), 64'(base));
        check("wrap.t1", 64'(lane_tnew(1)), 64'(e1));
        check("wrap.t2", 64'(lane_tnew(2)), 64'(e2));

        // Over-retire when only one entry is live.
        cycle(0, 2, 0, "to1");
        cycle(0, 3, 0, "overret");
        check("overret.valid", 64'(rob_outputs_valid), 64'd0);
        check("overret.spots", 64'(rob_spots), 64'd3);

        // Asynchronous reset between edges with five live entries.
        cycle(3, 0, 0, "pre0");
        cycle(2, 0, 0, "pre1");
        #2 reset = 1'b0;
        #1;
        check("midrst.valid", 64'(rob_outputs_valid), 64'd0);
        check("midrst.spots", 64'(rob_spots), 64'd3);
        check("midrst.lanes", 64'(rob_outputs), 64'd0);
        exp_q.delete();
        #1 reset = 1'b1;
        @(negedge clock);
        check_outputs("midrst.after");
        cycle(3, 0, 0, "midrst.disp");

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 24) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer: N-wide in-order dispatch at the tail, N-wide in-order retire at the head.
- Drives the retire interface: presents the oldest up-to-N entries (T_new, T_old) with a valid count, and pops the number of entries the retire stage reports retired.
- Sits between dispatch and the retire stage; the retire stage in turn feeds freed physical registers to the freelist.

Parameters:
- N, 3, superscalar width (lanes per cycle); 1 <= N <= ROB_SZ.
- ROB_SZ, 32, number of entries; power of two.
- PREG_W, 6, physical register index width.
- CNT_W, $clog2(N+1), width of all per-cycle count ports (derived; do not override).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- squash  in  1  flush all entries (mispredict recovery).
- rob_inputs  in  N*2*PREG_W  dispatch packets; lane i = {T_new, T_old}; lane 0 is oldest.
- rob_inputs_valid  in  CNT_W  number of dispatch lanes valid, 0..N; always lanes 0..k-1.
- rob_spots  out  CNT_W  free entries, saturated at N.
- rob_outputs  out  N*2*PREG_W  head packets; lane i = entry at (head+i) mod ROB_SZ.
- rob_outputs_valid  out  CNT_W  valid head lanes = min(count, N).
- num_retiring  in  CNT_W  entries popped this cycle, from the retire stage.

Behaviour:
- State: entry array [ROB_SZ] of {T_new, T_old}; head and tail pointers, log2(ROB_SZ) bits, wrapping naturally; count register, log2(ROB_SZ)+1 bits, range 0..ROB_SZ.
- Reset (async, reset==0): head=tail=count=0. Outputs take effect immediately: rob_outputs_valid=0, rob_spots=N, rob_outputs all zero. Entry contents need not be cleared.
- Outputs are combinational from registered state only:
  - rob_spots = min(ROB_SZ-count, N).
  - rob_outputs_valid = min(count, N).
  - Lanes i >= rob_outputs_valid drive 0.
  - No path from any input to any output.
- Dispatch: acc_d = min(rob_inputs_valid, rob_spots).
  - Lane i < acc_d is written to entry (tail+i) mod ROB_SZ at the clock edge; tail += acc_d.
  - Excess lanes are silently dropped; they never overwrite live entries.
- Retire: acc_r = min(num_retiring, rob_outputs_valid); head += acc_r.
- Same-cycle dispatch and retire are legal: count_next = count + acc_d - acc_r.
  - Spots are computed from pre-retire count, so a full ROB accepts nothing even while retiring.
- Squash: head=tail=count=0 at the next edge. Squash has priority over same-cycle dispatch and retire; both are discarded.
- Wrap-around: entries straddling index ROB_SZ-1 -> 0 appear in correct age order on rob_outputs.
- Full (count==ROB_SZ): rob_spots=0.
- Empty (count==0): rob_outputs_valid=0, num_retiring ignored.
- Reset mid-operation: asserting reset between edges clears state immediately; the first edge after deassertion behaves as from empty.

Optional Feature:
- Macro: REORDER_BUFFER_SPOT_BYPASS_EN.
- Defined: rob_spots = min(ROB_SZ-count+acc_r, N) and acc_d uses this value. This adds a combinational path num_retiring -> rob_spots, and a full ROB that retires k entries accepts up to k dispatches in the same cycle. Squash behaviour is unchanged.
- Undefined: behaviour as specified above; outputs are registered-state only.

Test Plan (N=3, ROB_SZ=8, PREG_W=6):
- Reset low at t0, then release -> rob_outputs_valid=0, rob_spots=3, rob_outputs=0. Assert reset between edges with count=5 -> rob_outputs_valid=0 before the next edge.
- Dispatch 3,3,2 over three cycles with T_new=1..8, no retire -> count 8, rob_spots=0, rob_outputs_valid=3, lanes T_new=1,2,3.
- Full ROB, rob_inputs_valid=2, num_retiring=0 -> nothing written, count stays 8.
  - With REORDER_BUFFER_SPOT_BYPASS_EN and num_retiring=2 -> both accepted, count stays 8, head T_new=3.
- Head=5, count=3, num_retiring=3, dispatch 3 same cycle -> head=0, tail wraps from 0 to 3, count=3. Next cycle lanes show the new packets in order.
- num_retiring=3 with count=1 -> acc_r=1, count=0, rob_outputs_valid=0, rob_spots=3.
- Count=5, squash=1 with rob_inputs_valid=3 and num_retiring=2 -> next cycle count=0, rob_spots=3, rob_outputs_valid=0.
